// File: rtl/bcd_pkg.sv
// Shared types, defaults and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGITS_DEF = 8;
  localparam int unsigned BIN_W_DEF  = 27;
  localparam int unsigned BCD_W      = 4 * DIGITS_DEF;
  localparam int unsigned MAX_DEC    = 99_999_999;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Double-dabble digit correction: a digit of 5..9 becomes 8..12 so the next shift carries.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

  // Largest value representable in the given number of decimal digits.
  function automatic logic [63:0] max_dec(input int unsigned digits);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a producer and the binary-to-BCD converter.
interface bin2bcd_seq_if import bcd_pkg::*; #(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_bin;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_ovf;

  modport master (
    output in_valid,
    output in_bin,
    input  in_ready,
    input  out_valid,
    input  out_bcd,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    output in_ready,
    output out_valid,
    output out_bcd,
    output out_ovf
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for a single BCD digit.
module bcd_digit_adj import bcd_pkg::*; (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Pure function of the current digit value.
  always_comb begin
    adjusted = add3_if_ge5(digit);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-add-3).
// The last result is held on the outputs for a free-running display scanner.
module bin2bcd_seq import bcd_pkg::*; #(
  parameter int unsigned BIN_W  = BIN_W_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned     BcdW    = 4 * DIGITS;
  localparam int unsigned     CntW    = $clog2(BIN_W);
  localparam logic [63:0]     MaxVal  = max_dec(DIGITS);
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   bcd_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_valid_q, out_valid_d;
  logic [63:0]       bin_ext;
  logic              unused_adj_msb;

  assign bin_ext = 64'(bus.in_bin);
  // Top bit of the accumulator falls off on shift; only reachable on overflow, which saturates.
  assign unused_adj_msb = bcd_adj[BcdW-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_bcd_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_bcd_q   <= out_bcd_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update for accept / shift / publish.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_bcd_d   = out_bcd_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          bin_d   = bus.in_bin;
          bcd_d   = '0;
          ovf_d   = (bin_ext > MaxVal);
          cnt_d   = CntLast;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj[BcdW-2:0], bin_q, 1'b0};
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        out_bcd_d   = ovf_q ? {DIGITS{4'h9}} : bcd_q;
        out_ovf_d   = ovf_q;
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_bcd   = out_bcd_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;

  localparam int unsigned BinW   = 27;
  localparam int unsigned Digits = 8;
  localparam int          Lat    = BinW + 1;  // edges from acceptance to the out_valid edge

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  bin2bcd_seq_if #(.BIN_W(BinW), .DIGITS(Digits)) bus ();

  bin2bcd_seq #(.BIN_W(BinW), .DIGITS(Digits)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, saturating above eight digits.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    if (v > 99_999_999) return 32'h9999_9999;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Drives one request from a negedge and returns at the negedge that shows out_valid.
  task automatic run_conv(input int unsigned v, input bit junk, input bit hold,
                          output logic [31:0] bcd, output logic ovf, output int edges,
                          output int busy, output bit pulse, output bit stable);
    logic [31:0] prev_bcd;
    logic        prev_ovf;
    for (int k = 0; k < 100 && !bus.in_ready; k++) @(negedge clk);
    prev_bcd = bus.out_bcd;
    prev_ovf = bus.out_ovf;
    bus.in_valid = 1'b1;
    bus.in_bin   = BinW'(v);
    @(negedge clk);
    edges = 0; busy = 0; pulse = 1'b0; stable = 1'b1; bcd = 'x; ovf = 1'bx;
    for (int k = 0; k < 60; k++) begin
      if (bus.out_valid) begin
        pulse = 1'b1;
        bcd = bus.out_bcd;
        ovf = bus.out_ovf;
        bus.in_valid = 1'b0;
        break;
      end
      if (!bus.in_ready) busy++;
      if (bus.out_bcd !== prev_bcd || bus.out_ovf !== prev_ovf) stable = 1'b0;
      if (hold) begin
        bus.in_valid = 1'b1;
      end else if (junk && !bus.in_ready) begin
        bus.in_valid = 1'($urandom);
        bus.in_bin   = BinW'($urandom);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bin = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bcd !== 32'h0 ||
        bus.out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b bcd=%h ovf=%b, want 1 0 00000000 0",
               bus.in_ready, bus.out_valid, bus.out_bcd, bus.out_ovf);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [31:0] bcd; logic ovf; int edges, busy; bit pulse, stable;
    run_conv(0, 1'b0, 1'b0, bcd, ovf, edges, busy, pulse, stable);
    vectors++;
    if (!pulse || bcd !== 32'h0 || ovf !== 1'b0 || edges != Lat || busy != Lat) begin
      miscompares++;
      $display("FAIL zero: pulse=%0d bcd=%h ovf=%b edges=%0d busy=%0d, want 1 0 0 %0d %0d",
               pulse, bcd, ovf, edges, busy, Lat, Lat);
    end
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_bcd !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_pulse_width: vld=%b bcd=%h, want 0 00000000", bus.out_valid, bus.out_bcd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bcd; logic ovf; int edges, busy; bit pulse, stable;
    run_conv(12_345_678, 1'b0, 1'b0, bcd, ovf, edges, busy, pulse, stable);
    vectors++;
    if (!pulse || bcd !== 32'h1234_5678 || ovf !== 1'b0 || edges != Lat) begin
      miscompares++;
      $display("FAIL b2b_first: pulse=%0d bcd=%h ovf=%b edges=%0d, want 1 12345678 0 %0d",
               pulse, bcd, ovf, edges, Lat);
    end
    run_conv(9, 1'b0, 1'b0, bcd, ovf, edges, busy, pulse, stable);
    vectors++;
    if (!pulse || bcd !== 32'h0000_0009 || ovf !== 1'b0 || edges != Lat || !stable) begin
      miscompares++;
      $display("FAIL b2b_second: pulse=%0d bcd=%h ovf=%b edges=%0d stable=%0d, want 1 9 0 %0d 1",
               pulse, bcd, ovf, edges, stable, Lat);
    end
  endtask

  task automatic test_boundary();
    int unsigned vals [3] = '{99_999_999, 100_000_000, 42};
    logic [31:0] bcd; logic ovf; int edges, busy; bit pulse, stable;
    foreach (vals[i]) begin
      @(negedge clk);
      run_conv(vals[i], 1'b0, 1'b0, bcd, ovf, edges, busy, pulse, stable);
      vectors++;
      if (!pulse || bcd !== ref_bcd(vals[i]) || ovf !== (vals[i] > 99_999_999)) begin
        miscompares++;
        $display("FAIL boundary %0d: pulse=%0d bcd=%h ovf=%b, want 1 %h %b", vals[i], pulse, bcd,
                 ovf, ref_bcd(vals[i]), vals[i] > 99_999_999);
      end
    end
  endtask

  task automatic test_hold_valid();
    logic [31:0] bcd; logic ovf; int edges, busy; bit pulse, stable;
    @(negedge clk);
    run_conv(555, 1'b0, 1'b0, bcd, ovf, edges, busy, pulse, stable);
    vectors++;
    if (!pulse || bcd !== 32'h0000_0555) begin
      miscompares++;
      $display("FAIL hold_prep: pulse=%0d bcd=%h, want 1 00000555", pulse, bcd);
    end
    // in_valid stays high with 777 from the cycle in_ready returns through the whole conversion
    run_conv(777, 1'b0, 1'b1, bcd, ovf, edges, busy, pulse, stable);
    vectors++;
    if (!pulse || bcd !== 32'h0000_0777 || edges != Lat || !stable) begin
      miscompares++;
      $display("FAIL hold_valid: pulse=%0d bcd=%h edges=%0d stable=%0d, want 1 00000777 %0d 1",
               pulse, bcd, edges, stable, Lat);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] bcd; logic ovf; int edges, busy; bit pulse, stable;
    int seen;
    @(negedge clk);
    run_conv(1234, 1'b0, 1'b0, bcd, ovf, edges, busy, pulse, stable);
    vectors++;
    if (!pulse || bcd !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL abort_prep: pulse=%0d bcd=%h, want 1 00001234", pulse, bcd);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin = BinW'(87_654_321);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_bcd !== 32'h0 || bus.out_ovf !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_async: bcd=%h ovf=%b vld=%b rdy=%b, want 00000000 0 0 1",
               bus.out_bcd, bus.out_ovf, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    vectors++;
    if (seen != 0 || bus.in_ready !== 1'b1 || bus.out_bcd !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_no_pulse: pulses=%0d rdy=%b bcd=%h, want 0 1 00000000",
               seen, bus.in_ready, bus.out_bcd);
    end
  endtask

  task automatic test_random();
    logic [31:0] bcd; logic ovf; int edges, busy; bit pulse, stable;
    int unsigned v;
    for (int n = 0; n < 24; n++) begin
      unique case (n % 4)
        0:       v = $urandom_range(0, 99_999_999);
        1:       v = $urandom_range(99_999_990, 100_000_010);
        2:       v = $urandom_range(0, 999);
        default: v = $urandom_range(0, (1 << BinW) - 1);
      endcase
      run_conv(v, 1'b1, 1'b0, bcd, ovf, edges, busy, pulse, stable);
      vectors++;
      if (!pulse || bcd !== ref_bcd(v) || ovf !== (v > 99_999_999) || edges != Lat ||
          busy != Lat || !stable) begin
        miscompares++;
        $display("FAIL random %0d: pulse=%0d bcd=%h ovf=%b edges=%0d busy=%0d stable=%0d, want 1 %h %b %0d %0d 1",
                 v, pulse, bcd, ovf, edges, busy, stable, ref_bcd(v), v > 99_999_999, Lat, Lat);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_boundary();
    test_hold_valid();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one input bit per clock.
- Sits directly upstream of the 8-digit multiplexed seven-segment scan driver.
- Turns a binary count or measurement into 8 packed BCD digits.
- Holds the last result stable on its outputs so the free-running scanner can read it at any time.

Parameters:
- BIN_W, 27, width of binary input; 2^27 covers 0..99,999,999.
- DIGITS, 8, number of BCD digits produced; matches the 8 display positions.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request to convert in_bin.
- in_ready  out  1  high when idle; a conversion is accepted on a rising edge with in_valid && in_ready.
- in_bin  in  BIN_W  unsigned binary value, sampled only on acceptance.
- out_valid  out  1  one-cycle pulse when out_bcd/out_ovf update.
- out_bcd  out  4*DIGITS  packed BCD; digit 0 (least significant) is in bits [3:0], digit 7 in [31:28]; held between updates.
- out_ovf  out  1  set if the last accepted value exceeded 10^DIGITS-1; held with out_bcd.

Behaviour:
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, internal shift/BCD regs=0, bit counter=0.
  - A reset mid-conversion aborts the conversion; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1. On in_valid at edge T:
    - Latch in_bin into the shift register.
    - Clear the BCD accumulator.
    - Latch ovf_q = (in_bin > 10^DIGITS-1).
    - Load bit counter = BIN_W-1.
    - Go to SHIFT.
  - SHIFT: in_ready=0. Each edge:
    - Every BCD digit >= 5 gets +3 (combinational, all digits in parallel).
    - Then {bcd, bin} shifts left by 1.
    - Counter decrements.
    - When the counter is 0 at the edge, go to DONE.
    - This produces exactly BIN_W shifts, on edges T+1..T+BIN_W.
  - DONE: one cycle, in_ready=0. At edge T+BIN_W+1:
    - out_bcd <= ovf_q ? all digits 4'h9 (saturate to 99,999,999) : bcd.
    - out_ovf <= ovf_q.
    - out_valid <= 1.
    - Go to IDLE.
  - out_valid falls at the next edge.
- Latency: acceptance at edge T, result visible after edge T+BIN_W+1 (28 cycles default). Throughput is one conversion per BIN_W+2 cycles.
- in_valid while in_ready=0 is ignored; no queuing. in_bin is don't-care outside acceptance.
- out_bcd/out_ovf change only on out_valid edges.
- Each BCD digit never exceeds 9 at any point during the conversion.
- Width rules: all arithmetic unsigned. The adjust is a 4-bit add with no carry out (input range 5..9 gives 8..12). The BCD accumulator is 4*DIGITS bits; bits shifted out of the top are discarded (only possible on overflow, covered by saturation).
- Simultaneous events: rst overrides everything. In IDLE, acceptance and an out_valid pulse from the previous conversion cannot coincide, because DONE precedes IDLE.

Decomposition:
- Shared package bcd_pkg:
  - DIGITS_DEF=8, BIN_W_DEF=27, BCD_W=4*DIGITS.
  - MAX_DEC = 99_999_999.
  - State enum {IDLE, SHIFT, DONE}.
  - Function add3_if_ge5(4-bit).
- Sub-module bcd_digit_adj: combinational, one 4-bit digit in, adjusted digit out. Instantiated DIGITS times via generate.

Test Plan:
- Reset, then in_bin=0 with in_valid one cycle:
  - in_ready low for 28 cycles.
  - out_valid pulses once.
  - out_bcd=32'h0000_0000, out_ovf=0.
- in_bin=12,345,678 → after 28 cycles out_bcd=32'h1234_5678, out_ovf=0. Back-to-back: in_bin=9 accepted on the cycle in_ready returns → out_bcd=32'h0000_0009.
- in_bin=99,999,999 → out_bcd=32'h9999_9999, out_ovf=0.
- in_bin=100,000,000 → out_bcd=32'h9999_9999, out_ovf=1.
  - Then in_bin=42 → out_bcd=32'h0000_0042, out_ovf=0.
- After a completed conversion of 555, hold in_valid=1 with in_bin=777 throughout:
  - 777 is accepted once in_ready returns high.
  - Inputs changing during SHIFT do not alter the result (777).
  - out_bcd stays 32'h0000_0555 until the 777 result's out_valid.
- After a completed 1234 result, assert rst at cycle 10 of a conversion of 87,654,321:
  - Outputs go to 0 immediately, asynchronously.
  - in_ready=1 after release.
  - No out_valid pulse for the aborted value.
